// File: rtl/sprite_dma_pkg.sv
// sprite_dma_pkg: sprite table geometry, attribute byte layout and DMA state/mode types
package sprite_dma_pkg;
  localparam int SPR_COUNT       = 16;
  localparam int SPR_BYTES       = 4;
  localparam int SPR_TABLE_BYTES = SPR_COUNT * SPR_BYTES;
  localparam int SPR_OFS_YU      = 0;
  localparam int SPR_OFS_YL      = 1;
  localparam int SPR_OFS_XU      = 2;
  localparam int SPR_OFS_XL      = 3;
  localparam int SPR_ENABLE_BIT  = 7;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RD, S_LAT, S_WR, S_FIN} dma_state_e;
  typedef enum logic {M_COPY, M_CLR} dma_mode_e;
endpackage

// File: rtl/sprite_dma.sv
// sprite_dma: copies or zero-fills the sprite attribute table during vertical blank
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [15:0] src_base,
  input  logic        vblank,
  output logic [15:0] wram_addr,
  output logic        wram_rd,
  input  logic [7:0]  wram_data_out,
  output logic [6:0]  spriteram_addr,
  output logic        spriteram_wr,
  output logic [7:0]  spriteram_data_in,
  output logic        busy,
  output logic        done
);
  localparam logic [6:0] CNT_LAST = 7'(SPR_TABLE_BYTES - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  dma_state_e  state_q, state_d;
  dma_mode_e   mode_q, mode_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  lat_q, lat_d;
  logic [15:0] src_q, src_d;
  logic        vblank_last_q;

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mode_q        <= M_COPY;
      cnt_q         <= '0;
      lat_q         <= '0;
      src_q         <= '0;
      vblank_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      src_q         <= src_d;
      vblank_last_q <= vblank;
    end
  end

  // Next-state: arm on request, start only on a fresh vblank rising edge
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    src_d   = src_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          mode_d  = M_CLR;
          cnt_d   = '0;
          state_d = S_ARM;
        end else if (start) begin
          mode_d  = M_COPY;
          src_d   = src_base;
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: if (vblank && !vblank_last_q) state_d = (mode_q == M_CLR) ? S_WR : S_RD;
      S_RD: begin
        lat_d   = '0;
        state_d = S_LAT;
      end
      S_LAT: begin
        if (lat_q == LAT_LAST) state_d = S_WR;
        else lat_d = lat_q + 2'd1;
      end
      S_WR: begin
        if (cnt_q == CNT_LAST) state_d = S_FIN;
        else begin
          cnt_d   = cnt_q + 7'd1;
          state_d = (mode_q == M_CLR) ? S_WR : S_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset zeroes them on the same edge
  always_comb begin
    wram_rd           = state_q == S_RD;
    wram_addr         = wram_rd ? src_q + {9'd0, cnt_q} : '0;
    spriteram_wr      = state_q == S_WR;
    spriteram_addr    = spriteram_wr ? cnt_q : '0;
    spriteram_data_in = (spriteram_wr && mode_q == M_COPY) ? wram_data_out : '0;
    busy              = state_q != S_IDLE && state_q != S_FIN;
    done              = state_q == S_FIN;
  end
endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: directed scenarios for the sprite attribute DMA
module tb_sprite_dma;
  logic        clk = 1'b0;
  logic        reset, start, clear, vblank;
  logic [15:0] src_base;
  logic [15:0] wram_addr;
  logic        wram_rd;
  logic [7:0]  wram_data_out;
  logic [6:0]  spriteram_addr;
  logic        spriteram_wr;
  logic [7:0]  spriteram_data_in;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0]  wram [0:65535];
  logic [6:0]  wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];
  logic        wr_b[$];
  logic [15:0] rd_a[$];

  sprite_dma dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .src_base(src_base),
    .vblank(vblank), .wram_addr(wram_addr), .wram_rd(wram_rd), .wram_data_out(wram_data_out),
    .spriteram_addr(spriteram_addr), .spriteram_wr(spriteram_wr),
    .spriteram_data_in(spriteram_data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wram_rd) wram_data_out <= wram[wram_addr];
  end

  always @(negedge clk) begin
    if (spriteram_wr) begin
      wr_a.push_back(spriteram_addr);
      wr_d.push_back(spriteram_data_in);
      wr_c.push_back(cyc);
      wr_b.push_back(busy);
    end
    if (wram_rd) rd_a.push_back(wram_addr);
    if (done) done_cnt++;
  end

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); wr_b.delete(); rd_a.delete();
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] a);
    tick(1);
    start = 1'b1; src_base = a;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_timeout: done got 0 required 1 within 400 cycles", nm); end
    tick(1);
  endtask

  task automatic check_copy(input string nm, input logic [15:0] base, input int gap);
    n_cmp++;
    if (wr_a.size() !== 64) begin n_bad++; $display("FAIL %s_count: got %0d required 64", nm, wr_a.size()); end
    for (int i = 0; i < 64 && i < wr_a.size(); i++) begin
      n_cmp++;
      if (wr_a[i] !== 7'(i) || wr_d[i] !== wram[16'(base + i)] || wr_b[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_byte%0d: got a=%h d=%h busy=%b required a=%h d=%h busy=1", nm, i, wr_a[i], wr_d[i], wr_b[i], 7'(i), wram[16'(base + i)]);
      end
      if (i > 0) begin
        n_cmp++;
        if (wr_c[i] - wr_c[i-1] !== gap) begin n_bad++; $display("FAIL %s_gap%0d: got %0d required %0d", nm, i, wr_c[i] - wr_c[i-1], gap); end
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done: got %0d required 1", nm, done_cnt); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after: got %b required 0", nm, busy); end
  endtask

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if ({wram_addr, wram_rd, spriteram_addr, spriteram_wr, spriteram_data_in, busy, done} !== 35'd0) begin
      n_bad++;
      $display("FAIL %s: got wa=%h rd=%b sa=%h wr=%b sd=%h busy=%b done=%b required all 0", nm, wram_addr, wram_rd, spriteram_addr, spriteram_wr, spriteram_data_in, busy, done);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check_idle_outputs("reset_outputs");
    reset = 1'b1;
    tick(2);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_copy();
    clear_log();
    pulse_start(16'h4000);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL copy_busy_accept: got %b required 1", busy); end
    tick(5);
    n_cmp++;
    if (wr_a.size() !== 0) begin n_bad++; $display("FAIL copy_prearm_writes: got %0d required 0", wr_a.size()); end
    vblank = 1'b1;
    wait_done("copy");
    check_copy("copy", 16'h4000, 3);
    vblank = 1'b0;
  endtask

  task automatic test_clear();
    clear_log();
    tick(2);
    pulse_clear();
    tick(3);
    vblank = 1'b1;
    wait_done("clear");
    n_cmp++;
    if (wr_a.size() !== 64) begin n_bad++; $display("FAIL clear_count: got %0d required 64", wr_a.size()); end
    for (int i = 0; i < 64 && i < wr_a.size(); i++) begin
      n_cmp++;
      if (wr_a[i] !== 7'(i) || wr_d[i] !== 8'h00 || (i > 0 && wr_c[i] - wr_c[i-1] !== 1)) begin
        n_bad++;
        $display("FAIL clear_byte%0d: got a=%h d=%h required a=%h d=00 consecutive", i, wr_a[i], wr_d[i], 7'(i));
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL clear_done: got %0d required 1", done_cnt); end
    vblank = 1'b0;
  endtask

  task automatic test_arming();
    clear_log();
    vblank = 1'b1;
    tick(3);
    pulse_start(16'h4000);
    tick(10);
    n_cmp++;
    if (wr_a.size() !== 0) begin n_bad++; $display("FAIL arm_vblank_high: got %0d writes required 0", wr_a.size()); end
    vblank = 1'b0;
    tick(5);
    n_cmp++;
    if (wr_a.size() !== 0 || busy !== 1'b1) begin n_bad++; $display("FAIL arm_vblank_low: got %0d writes busy=%b required 0 writes busy=1", wr_a.size(), busy); end
    vblank = 1'b1;
    wait_done("arm");
    check_copy("arm", 16'h4000, 3);
    vblank = 1'b0;
  endtask

  task automatic test_ignored();
    clear_log();
    pulse_start(16'h4000);
    tick(2);
    vblank = 1'b1;
    for (int i = 0; i < 200 && wr_a.size() < 10; i++) tick(1);
    pulse_start(16'h8000);
    wait_done("ignored");
    check_copy("ignored", 16'h4000, 3);
    tick(300);
    n_cmp++;
    if (wr_a.size() !== 64 || done_cnt !== 1) begin n_bad++; $display("FAIL ignored_second: got %0d writes %0d done required 64 and 1", wr_a.size(), done_cnt); end
    vblank = 1'b0;
  endtask

  task automatic test_wrap();
    clear_log();
    pulse_start(16'hFFF0);
    tick(2);
    vblank = 1'b1;
    wait_done("wrap");
    n_cmp++;
    if (rd_a.size() !== 64) begin n_bad++; $display("FAIL wrap_reads: got %0d required 64", rd_a.size()); end
    for (int i = 0; i < 64 && i < rd_a.size(); i++) begin
      n_cmp++;
      if (rd_a[i] !== 16'(32'hFFF0 + i)) begin n_bad++; $display("FAIL wrap_addr%0d: got %h required %h", i, rd_a[i], 16'(32'hFFF0 + i)); end
    end
    check_copy("wrap", 16'hFFF0, 3);
    vblank = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_log();
    pulse_start(16'h4000);
    tick(2);
    vblank = 1'b1;
    for (int i = 0; i < 200 && wr_a.size() < 20; i++) tick(1);
    reset = 1'b0;
    tick(1);
    check_idle_outputs("midreset_outputs");
    reset = 1'b1;
    n = wr_a.size();
    tick(20);
    n_cmp++;
    if (done_cnt !== 0 || wr_a.size() !== n || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_quiet: got done=%0d extra_writes=%0d busy=%b required 0 0 0", done_cnt, wr_a.size() - n, busy);
    end
    vblank = 1'b0;
    tick(2);
    clear_log();
    pulse_start(16'h4000);
    tick(2);
    vblank = 1'b1;
    wait_done("restart");
    check_copy("restart", 16'h4000, 3);
    vblank = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) wram[i] = 8'(i ^ 8'h5A);
    for (int i = 0; i < 64; i++) wram[16'h4000 + i] = 8'(8'h80 + i);
    for (int i = 0; i < 64; i++) wram[16'h8000 + i] = 8'h11;
    reset = 1'b0; start = 1'b0; clear = 1'b0; vblank = 1'b0; src_base = '0;
    test_reset();
    test_copy();
    test_clear();
    test_arming();
    test_ignored();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
